// File: rtl/arashi_mem_writer.sv
// Memory-side writer for arashi_cache: captures granted words one cycle after the grant,
// buffers them with their thread tag and issues per-thread incrementing word writes.
module arashi_mem_writer #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int ADDR_WIDTH       = 16,
  parameter int FIFO_DEPTH_WIDTH = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               cache_ready,
  input  logic [THREAD_NUM_WIDTH-1:0]        thread_id,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic                               mem_ready,
  output logic                               mem_wvalid,
  input  logic                               mem_wready,
  output logic [ADDR_WIDTH-1:0]              mem_waddr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0]   clr_ptr,
  input  logic                               flush_req,
  output logic                               flush_done,
  output logic                               overflow
);

  localparam int THREAD_NUM  = 1 << THREAD_NUM_WIDTH;
  localparam int FIFO_DEPTH  = 1 << FIFO_DEPTH_WIDTH;
  localparam int OFF_WIDTH   = ADDR_WIDTH - THREAD_NUM_WIDTH;
  localparam int ENTRY_WIDTH = THREAD_NUM_WIDTH + DATA_WIDTH;

  localparam logic [FIFO_DEPTH_WIDTH:0]   DEPTH_CNT = (FIFO_DEPTH_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_WIDTH+1:0] DEPTH_OCC = (FIFO_DEPTH_WIDTH+2)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_WIDTH:0]   CNT_ONE   = (FIFO_DEPTH_WIDTH+1)'(1);
  localparam logic [FIFO_DEPTH_WIDTH-1:0] PTR_ONE   = (FIFO_DEPTH_WIDTH)'(1);
  localparam logic [OFF_WIDTH-1:0]        OFF_ONE   = (OFF_WIDTH)'(1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                          alive;
  logic                          pend;
  logic [THREAD_NUM_WIDTH-1:0]   tid_q;

  logic [ENTRY_WIDTH-1:0]        fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_WIDTH-1:0]   wr_ptr;
  logic [FIFO_DEPTH_WIDTH-1:0]   rd_ptr;
  logic [FIFO_DEPTH_WIDTH:0]     count;

  logic [OFF_WIDTH-1:0]          offset [THREAD_NUM];

  logic                          fifo_empty;
  logic                          fifo_full;
  logic                          push;
  logic                          pop;
  logic                          grant;
  logic                          credit;
  logic [FIFO_DEPTH_WIDTH+1:0]   occ_sum;
  logic [ENTRY_WIDTH-1:0]        head;
  logic [THREAD_NUM_WIDTH-1:0]   head_tid;
  logic [DATA_WIDTH-1:0]         head_data;

  // Credit ignores same-cycle pops, so the in-flight grant can never find the FIFO full.
  assign occ_sum    = {1'b0, count} + {{(FIFO_DEPTH_WIDTH+1){1'b0}}, pend};
  assign credit     = occ_sum < DEPTH_OCC;
  assign mem_ready  = alive & (state == ST_RUN) & ~flush_req & credit;
  assign grant      = cache_ready & mem_ready;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_CNT);
  assign push       = pend & ~fifo_full;
  assign pop        = mem_wvalid & mem_wready;

  assign head       = fifo_mem[rd_ptr];
  assign head_tid   = head[ENTRY_WIDTH-1 -: THREAD_NUM_WIDTH];
  assign head_data  = head[DATA_WIDTH-1:0];

  // Address and data are forced to zero while idle so reset and empty look identical outside.
  assign mem_wvalid = ~fifo_empty;
  assign mem_waddr  = mem_wvalid ? {head_tid, offset[head_tid]} : '0;
  assign mem_wdata  = mem_wvalid ? head_data : '0;
  assign flush_done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alive <= 1'b0;
      pend  <= 1'b0;
      tid_q <= '0;
    end else begin
      alive <= 1'b1;
      pend  <= grant;
      tid_q <= thread_id;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {tid_q, data_in};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (pend && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // A clear wins over an increment of the same thread; the address shown this cycle is unaffected.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < THREAD_NUM; i++) begin
        offset[i] <= '0;
      end
    end else begin
      for (int i = 0; i < THREAD_NUM; i++) begin
        if (clr_ptr[i]) begin
          offset[i] <= '0;
        end else if (pop && (head_tid == THREAD_NUM_WIDTH'(i))) begin
          offset[i] <= offset[i] + OFF_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN: begin
        if (flush_req) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !pend) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_arashi_mem_writer.sv
// Directed bench for arashi_mem_writer: reset, single writes, backpressure, wrap/clear, flush, reset mid-burst.
module tb_arashi_mem_writer;

  logic        clk;
  logic        rstn;
  logic        cache_ready;
  logic [1:0]  thread_id;
  logic [31:0] data_in;
  logic        mem_ready;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [15:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  clr_ptr;
  logic        flush_req;
  logic        flush_done;
  logic        overflow;

  int vecCount  = 0;
  int missCount = 0;

  logic [15:0] waLog [$];
  logic [31:0] wdLog [$];

  arashi_mem_writer #(
    .DATA_WIDTH(32),
    .THREAD_NUM_WIDTH(2),
    .ADDR_WIDTH(16),
    .FIFO_DEPTH_WIDTH(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cache_ready(cache_ready),
    .thread_id(thread_id),
    .data_in(data_in),
    .mem_ready(mem_ready),
    .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .clr_ptr(clr_ptr),
    .flush_req(flush_req),
    .flush_done(flush_done),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side monitor records every accepted write just before the edge that completes it.
  always @(negedge clk) begin
    #4;
    if (mem_wvalid && mem_wready) begin
      waLog.push_back(mem_waddr);
      wdLog.push_back(mem_wdata);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic [1:0] tid, input logic [31:0] din,
                               input logic wr, input logic fl, input logic [3:0] clr);
    @(negedge clk);
    cache_ready = cr;
    thread_id   = tid;
    data_in     = din;
    mem_wready  = wr;
    flush_req   = fl;
    clr_ptr     = clr;
    #1;
  endtask

  // Offers words from one thread for up to 'cycles' cycles; data follows each grant by one cycle.
  task automatic streamWords(input logic [1:0] tid, input int n, input logic [31:0] base,
                             input logic wr, input int cycles, output int granted);
    int   cyc = 0;
    logic prevGrant = 1'b0;
    granted = 0;
    while ((cyc < cycles) || prevGrant) begin
      if ((granted >= n) && !prevGrant) break;
      applyStimulus((granted < n) && (cyc < cycles), tid,
                    prevGrant ? (base + 32'(granted) - 32'd1) : 32'h0, wr, 1'b0, 4'b0);
      prevGrant = cache_ready && mem_ready;
      if (prevGrant) granted++;
      cyc++;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 4'b0);
    end
  endtask

  function automatic logic [31:0] logAddr(input int k);
    if (k < waLog.size()) return {16'h0, waLog[k]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] logData(input int k);
    if (k < wdLog.size()) return wdLog[k];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int g;
    int pulses;
    int grants;

    rstn = 1'b0; cache_ready = 1'b0; thread_id = 2'd0; data_in = 32'h0;
    mem_wready = 1'b0; flush_req = 1'b0; clr_ptr = 4'b0;

    // 1: outputs held at zero while reset is asserted, whatever the inputs do
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cache_ready = 1'($urandom);
      thread_id   = 2'($urandom);
      data_in     = $urandom;
      mem_wready  = 1'($urandom);
      flush_req   = 1'($urandom);
      clr_ptr     = 4'($urandom);
      #1;
      checkOutput("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
      checkOutput("rst_wvalid", {31'h0, mem_wvalid}, 32'h0);
      checkOutput("rst_waddr", {16'h0, mem_waddr}, 32'h0);
      checkOutput("rst_wdata", mem_wdata, 32'h0);
      checkOutput("rst_flush_done", {31'h0, flush_done}, 32'h0);
      checkOutput("rst_overflow", {31'h0, overflow}, 32'h0);
    end
    @(negedge clk);
    rstn = 1'b1; cache_ready = 1'b0; thread_id = 2'd0; data_in = 32'h0;
    mem_wready = 1'b1; flush_req = 1'b0; clr_ptr = 4'b0;

    // 2: single word from thread 2, then a second one
    applyStimulus(1'b1, 2'd2, 32'h0, 1'b1, 1'b0, 4'b0);
    checkOutput("rel_mem_ready", {31'h0, mem_ready}, 32'h1);
    checkOutput("rel_wvalid", {31'h0, mem_wvalid}, 32'h0);
    applyStimulus(1'b0, 2'd0, 32'hA5A5_0001, 1'b1, 1'b0, 4'b0);
    checkOutput("one_latency_wvalid", {31'h0, mem_wvalid}, 32'h0);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 4'b0);
    checkOutput("one_wvalid", {31'h0, mem_wvalid}, 32'h1);
    checkOutput("one_waddr", {16'h0, mem_waddr}, 32'h0000_8000);
    checkOutput("one_wdata", mem_wdata, 32'hA5A5_0001);
    idleCycles(2);
    checkOutput("one_count", 32'(waLog.size()), 32'd1);
    checkOutput("one_log_addr", logAddr(0), 32'h0000_8000);
    checkOutput("one_log_data", logData(0), 32'hA5A5_0001);
    waLog.delete(); wdLog.delete();
    streamWords(2'd2, 1, 32'hA5A5_0002, 1'b1, 1, g);
    idleCycles(3);
    checkOutput("two_count", 32'(waLog.size()), 32'd1);
    checkOutput("two_log_addr", logAddr(0), 32'h0000_8001);
    checkOutput("two_log_data", logData(0), 32'hA5A5_0002);

    // 3: backpressure stops acceptance at the FIFO depth, then drains in order
    waLog.delete(); wdLog.delete();
    streamWords(2'd0, 100, 32'hB000_0000, 1'b0, 8, g);
    checkOutput("bp_grants", 32'(g), 32'd4);
    checkOutput("bp_mem_ready", {31'h0, mem_ready}, 32'h0);
    checkOutput("bp_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("bp_head_addr", {16'h0, mem_waddr}, 32'h0000_0000);
    checkOutput("bp_head_data", mem_wdata, 32'hB000_0000);
    checkOutput("bp_no_write", 32'(waLog.size()), 32'd0);
    idleCycles(6);
    checkOutput("bp_drain_count", 32'(waLog.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp_drain_addr", logAddr(k), 32'(k));
      checkOutput("bp_drain_data", logData(k), 32'hB000_0000 + 32'(k));
    end
    checkOutput("bp_ready_back", {31'h0, mem_ready}, 32'h1);

    // 4: walk thread 1 up to the last offset, check wrap, then clear
    streamWords(2'd1, 16383, 32'h1000_0000, 1'b1, 17000, g);
    checkOutput("wrap_fill", 32'(g), 32'd16383);
    idleCycles(4);
    waLog.delete(); wdLog.delete();
    streamWords(2'd1, 2, 32'hC000_0000, 1'b1, 4, g);
    idleCycles(4);
    checkOutput("wrap_count", 32'(waLog.size()), 32'd2);
    checkOutput("wrap_addr_top", logAddr(0), 32'h0000_7FFF);
    checkOutput("wrap_addr_zero", logAddr(1), 32'h0000_4000);
    checkOutput("wrap_data", logData(1), 32'hC000_0001);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 4'b0010);
    waLog.delete(); wdLog.delete();
    streamWords(2'd1, 1, 32'hC100_0000, 1'b1, 1, g);
    idleCycles(3);
    checkOutput("clr_addr", logAddr(0), 32'h0000_4000);

    // 5a: flush from idle blocks mem_ready in the request cycle and pulses done once
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 4'b0);
    checkOutput("flush_idle_ready", {31'h0, mem_ready}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 4'b0);
      if (flush_done) pulses++;
    end
    checkOutput("flush_idle_pulses", 32'(pulses), 32'd1);

    // 5b: flush with three words queued and one pending
    waLog.delete(); wdLog.delete();
    grants = 0;
    applyStimulus(1'b1, 2'd3, 32'h0, 1'b0, 1'b0, 4'b0);
    if (cache_ready && mem_ready) grants++;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 2'd3, 32'hD000_0000 + 32'(k), 1'b0, 1'b0, 4'b0);
      if (cache_ready && mem_ready) grants++;
    end
    checkOutput("flush_grants", 32'(grants), 32'd4);
    applyStimulus(1'b0, 2'd3, 32'hD000_0003, 1'b1, 1'b1, 4'b0);
    checkOutput("flush_ready_drop", {31'h0, mem_ready}, 32'h0);
    checkOutput("flush_done_early", {31'h0, flush_done}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 4'b0);
      if (flush_done) pulses++;
    end
    checkOutput("flush_pulses", 32'(pulses), 32'd1);
    checkOutput("flush_writes", 32'(waLog.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("flush_addr", logAddr(k), 32'h0000_C000 + 32'(k));
      checkOutput("flush_data", logData(k), 32'hD000_0000 + 32'(k));
    end
    checkOutput("flush_ready_back", {31'h0, mem_ready}, 32'h1);

    // 6: reset with three words buffered discards them and clears offsets
    streamWords(2'd0, 3, 32'hE000_0000, 1'b0, 3, g);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 4'b0);
    checkOutput("mid_wvalid_before", {31'h0, mem_wvalid}, 32'h1);
    waLog.delete(); wdLog.delete();
    @(negedge clk);
    rstn = 1'b0; mem_wready = 1'b1;
    #1;
    checkOutput("mid_rst_wvalid", {31'h0, mem_wvalid}, 32'h0);
    checkOutput("mid_rst_waddr", {16'h0, mem_waddr}, 32'h0);
    checkOutput("mid_rst_ready", {31'h0, mem_ready}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idleCycles(5);
    checkOutput("mid_no_stale", 32'(waLog.size()), 32'd0);
    streamWords(2'd0, 1, 32'hF000_0000, 1'b1, 1, g);
    idleCycles(3);
    checkOutput("mid_after_addr", logAddr(0), 32'h0000_0000);
    checkOutput("mid_after_data", logData(0), 32'hF000_0000);
    checkOutput("end_overflow", {31'h0, overflow}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
